// File: rtl/bmem_arbiter.sv
// Two-client line-memory arbiter: icache reads and dcache reads/writebacks share one bmem port.
// Build option BMEM_ARB_RR_EN: round-robin between clients; undefined gives fixed dcache priority.
module bmem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // icache client
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // dcache client
  input  logic [ADDR_W-1:0] d_addr,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // memory port
  output logic [ADDR_W-1:0] bmem_addr,
  output logic              bmem_read,
  output logic              bmem_write,
  output logic [LINE_W-1:0] bmem_wdata,
  input  logic [LINE_W-1:0] bmem_rdata,
  input  logic              bmem_resp
);

  localparam int OFF_W = $clog2(LINE_W / 8);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'((1 << OFF_W) - 1));

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic [LINE_W-1:0] i_rdata_q, i_rdata_d;
  logic [LINE_W-1:0] d_rdata_q, d_rdata_d;
  logic              i_resp_q, i_resp_d;
  logic              d_resp_q, d_resp_d;

  logic              d_req;
  logic              pick_dcache;
  logic [ADDR_W-1:0] sel_addr;

  assign d_req = d_read | d_write;

`ifdef BMEM_ARB_RR_EN
  // last_grant_q = 1 means the dcache was granted most recently
  logic last_grant_q, last_grant_d;
  assign pick_dcache = d_req && (!i_read || !last_grant_q);
`else
  assign pick_dcache = d_req;
`endif

  assign sel_addr = (pick_dcache ? d_addr : i_addr) & LINE_MASK;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_resp_q  <= 1'b0;
      d_resp_q  <= 1'b0;
`ifdef BMEM_ARB_RR_EN
      last_grant_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      read_q    <= read_d;
      write_q   <= write_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_resp_q  <= i_resp_d;
      d_resp_q  <= d_resp_d;
`ifdef BMEM_ARB_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    read_d    = read_q;
    write_d   = write_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_resp_d  = 1'b0;
    d_resp_d  = 1'b0;
`ifdef BMEM_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (d_req || i_read) begin
          addr_d = sel_addr;
`ifdef BMEM_ARB_RR_EN
          last_grant_d = pick_dcache;
`endif
          if (pick_dcache) begin
            // a writeback wins over a read when both strobes are raised
            state_d = SERVE_D;
            read_d  = !d_write;
            write_d = d_write;
            wdata_d = d_wdata;
          end else begin
            state_d = SERVE_I;
            read_d  = 1'b1;
            write_d = 1'b0;
          end
        end
      end
      SERVE_I: begin
        if (bmem_resp) begin
          read_d    = 1'b0;
          write_d   = 1'b0;
          i_rdata_d = bmem_rdata;
          i_resp_d  = 1'b1;
          state_d   = DONE;
        end
      end
      SERVE_D: begin
        if (bmem_resp) begin
          if (read_q) begin
            d_rdata_d = bmem_rdata;
          end
          read_d   = 1'b0;
          write_d  = 1'b0;
          d_resp_d = 1'b1;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bmem_addr  = addr_q;
  assign bmem_wdata = wdata_q;
  assign bmem_read  = read_q;
  assign bmem_write = write_q;
  assign i_rdata    = i_rdata_q;
  assign d_rdata    = d_rdata_q;
  assign i_resp     = i_resp_q;
  assign d_resp     = d_resp_q;

endmodule
